serial_mac_sched: RTL and testbench

Sequencer for the serial-mode datapath. It steps one single-port synchronous RAM through alternating weight and feature reads, registers each operand pair, and drives the PE accumulator with a clear pulse and per-tap enable pulses. It replaces the ad-hoc loader sequencing: software gives two base addresses and a tap count, pulses start, and waits for done.

---
 rtl/serial_ctrl_pkg.sv | 29 ++
 rtl/serial_mac_sched_tap_addr_gen.sv | 73 +++++++
 rtl/serial_mac_sched.sv | 146 ++++++++++++++
 tb/tb_serial_mac_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_ctrl_pkg.sv
// Shared definitions for the serial-mode MAC sequencer.
//   - Default widths for the RAM address, operand and tap-count buses.
//   - 3-bit state encoding for the sequencer FSM.
`timescale 1ns/1ps
package serial_ctrl_pkg;

    localparam int ADDR_W_DFLT = 6;
    localparam int DATA_W_DFLT = 8;
    localparam int CNT_W_DFLT  = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_RD_W  = 3'd2;
    localparam logic [2:0] ST_RD_F  = 3'd3;
    localparam logic [2:0] ST_LAT_F = 3'd4;
    localparam logic [2:0] ST_ACC   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CLR   = ST_CLR,
        S_RD_W  = ST_RD_W,
        S_RD_F  = ST_RD_F,
        S_LAT_F = ST_LAT_F,
        S_ACC   = ST_ACC,
        S_DONE  = ST_DONE
    } state_e;

endpackage : serial_ctrl_pkg

// File: rtl/serial_mac_sched_tap_addr_gen.sv
// tap_addr_gen: tap counter and modulo address generation.
// Holds the base addresses and tap count latched at launch, the running tap
// index, and produces base+index (wrapping modulo 2^ADDR_W) for both vectors.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load_i           latch bases/count and clear the tap index
//   inc_i            advance the tap index
//   w_base_i/f_base_i/num_taps_i  launch-time parameters
//   w_addr_o/f_addr_o  current weight / feature addresses
//   last_tap_o       current index is the final tap
//   zero_taps_o      latched tap count is zero
`timescale 1ns/1ps
module tap_addr_gen
    import serial_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int CNT_W  = CNT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] w_base_i,
    input  logic [ADDR_W-1:0] f_base_i,
    input  logic [CNT_W-1:0]  num_taps_i,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [ADDR_W-1:0] f_addr_o,
    output logic              last_tap_o,
    output logic              zero_taps_o
);

    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic [ADDR_W-1:0] f_base_q, f_base_d;
    logic [CNT_W-1:0]  num_taps_q, num_taps_d;
    logic [CNT_W-1:0]  idx_q, idx_d;

    always_comb begin
        w_base_d   = w_base_q;
        f_base_d   = f_base_q;
        num_taps_d = num_taps_q;
        idx_d      = idx_q;
        if (load_i) begin
            w_base_d   = w_base_i;
            f_base_d   = f_base_i;
            num_taps_d = num_taps_i;
            idx_d      = '0;
        end else if (inc_i) begin
            // Index peaks at num_taps-2 before incrementing, so it never wraps.
            idx_d = idx_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_base_q   <= '0;
            f_base_q   <= '0;
            num_taps_q <= '0;
            idx_q      <= '0;
        end else begin
            w_base_q   <= w_base_d;
            f_base_q   <= f_base_d;
            num_taps_q <= num_taps_d;
            idx_q      <= idx_d;
        end
    end

    // Sums are truncated to ADDR_W bits, giving modulo-2^ADDR_W wrap.
    assign w_addr_o    = w_base_q + ADDR_W'(idx_q);
    assign f_addr_o    = f_base_q + ADDR_W'(idx_q);
    assign last_tap_o  = (idx_q == (num_taps_q - CNT_W'(1)));
    assign zero_taps_o = (num_taps_q == '0);

endmodule : tap_addr_gen

// File: rtl/serial_mac_sched.sv
// serial_mac_sched: sequencer for the serial-mode MAC datapath.
// Steps a single-port synchronous RAM through alternating weight/feature
// reads, registers each operand pair and strobes the PE accumulator.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               launch request (honoured in IDLE only)
//   w_base, f_base      vector base addresses, latched at launch
//   num_taps            tap count, latched at launch
//   ram_addr, ram_we    RAM address / write enable (always 0)
//   ram_q               RAM read data, one cycle after ram_addr
//   w_out, f_out        registered operands to the PE
//   acc_clr, acc_en     accumulator clear / per-tap accumulate strobes
//   busy, done          run in progress / one-cycle completion pulse
`timescale 1ns/1ps
module serial_mac_sched
    import serial_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = CNT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] f_base,
    input  logic [CNT_W-1:0]  num_taps,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] w_out,
    output logic [DATA_W-1:0] f_out,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] w_out_q, w_out_d;
    logic [DATA_W-1:0] f_out_q, f_out_d;

    logic              load, inc;
    logic [ADDR_W-1:0] w_addr, f_addr;
    logic              last_tap, zero_taps;

    logic [ADDR_W-1:0] ram_addr_c;
    logic              acc_clr_c, acc_en_c, busy_c, done_c;

    tap_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_tap_addr_gen (
        .clk         (clk),
        .rst_n       (rst),
        .load_i      (load),
        .inc_i       (inc),
        .w_base_i    (w_base),
        .f_base_i    (f_base),
        .num_taps_i  (num_taps),
        .w_addr_o    (w_addr),
        .f_addr_o    (f_addr),
        .last_tap_o  (last_tap),
        .zero_taps_o (zero_taps)
    );

    always_comb begin
        state_d    = state_q;
        w_out_d    = w_out_q;
        f_out_d    = f_out_q;
        load       = 1'b0;
        inc        = 1'b0;
        ram_addr_c = '0;
        acc_clr_c  = 1'b0;
        acc_en_c   = 1'b0;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy_c = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                acc_clr_c = 1'b1;
                state_d   = zero_taps ? S_DONE : S_RD_W;
            end
            S_RD_W: begin
                ram_addr_c = w_addr;
                state_d    = S_RD_F;
            end
            S_RD_F: begin
                // ram_q now carries the weight addressed in RD_W.
                ram_addr_c = f_addr;
                w_out_d    = ram_q;
                state_d    = S_LAT_F;
            end
            S_LAT_F: begin
                // ram_q now carries the feature addressed in RD_F.
                f_out_d = ram_q;
                state_d = S_ACC;
            end
            S_ACC: begin
                acc_en_c = 1'b1;
                if (last_tap) begin
                    state_d = S_DONE;
                end else begin
                    inc     = 1'b1;
                    state_d = S_RD_W;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_c  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            w_out_q <= '0;
            f_out_q <= '0;
        end else begin
            state_q <= state_d;
            w_out_q <= w_out_d;
            f_out_q <= f_out_d;
        end
    end

    assign ram_addr = ram_addr_c;
    assign ram_we   = 1'b0;
    assign w_out    = w_out_q;
    assign f_out    = f_out_q;
    assign acc_clr  = acc_clr_c;
    assign acc_en   = acc_en_c;
    assign busy     = busy_c;
    assign done     = done_c;

endmodule : serial_mac_sched

// File: tb/tb_serial_mac_sched.sv
`timescale 1ns/1ps
module tb_serial_mac_sched;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] w_base, f_base;
    logic [CW-1:0] num_taps;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] w_out, f_out;
    logic          acc_clr, acc_en, busy, done;

    serial_mac_sched #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .w_base   (w_base),
        .f_base   (f_base),
        .num_taps (num_taps),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .w_out    (w_out),
        .f_out    (f_out),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous-read RAM.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) ram_q <= mem[ram_addr];

    int checks = 0;
    int errors = 0;
    int acc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap(input int a);
        return a & ((1 << AW) - 1);
    endfunction

    task automatic fill_random();
        for (int k = 0; k < (1 << AW); k++) mem[k] = DW'($urandom);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " busy"},    busy,     0);
        chk({tag, " done"},    done,     0);
        chk({tag, " acc_clr"}, acc_clr,  0);
        chk({tag, " acc_en"},  acc_en,   0);
        chk({tag, " addr"},    ram_addr, 0);
        chk({tag, " we"},      ram_we,   0);
    endtask

    // One complete run, checked cycle by cycle against the timing rules:
    // CLR in cycle 1, tap t spans cycles 4t+2..4t+5 (RD_W,RD_F,LAT_F,ACC),
    // done in cycle 4n+2. Entered and left at a sample point in IDLE.
    // intr_c > 0 pulses start with bases ib_w/ib_f during that cycle.
    task automatic run(input string tag, input int wb, input int fb, input int n,
                       input bit hold, input int intr_c, input int ib_w, input int ib_f);
        int exp_sum;
        int last;
        exp_sum = 0;
        for (int t = 0; t < n; t++)
            exp_sum += int'(mem[wrap(wb + t)]) * int'(mem[wrap(fb + t)]);
        last = 4 * n + 2;
        start    = 1'b1;
        w_base   = AW'(wb);
        f_base   = AW'(fb);
        num_taps = CW'(n);
        tick();
        if (!hold) start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            int  ph, t, e_addr;
            bit  e_en;
            ph = (c - 2) % 4;
            t  = (c - 2) / 4;
            e_addr = 0;
            if (c >= 2 && c <= last - 1) begin
                if (ph == 0) e_addr = wrap(wb + t);
                else if (ph == 1) e_addr = wrap(fb + t);
            end
            e_en = (c >= 5) && (c <= last - 1) && (ph == 3);
            chk($sformatf("%s clr c%0d", tag, c),  acc_clr, (c == 1));
            chk($sformatf("%s en c%0d", tag, c),   acc_en,  e_en);
            chk($sformatf("%s done c%0d", tag, c), done,    (c == last));
            chk($sformatf("%s busy c%0d", tag, c), busy,    1);
            chk($sformatf("%s addr c%0d", tag, c), ram_addr, e_addr);
            chk($sformatf("%s we c%0d", tag, c),   ram_we,  0);
            if (e_en) begin
                chk($sformatf("%s w c%0d", tag, c), w_out, mem[wrap(wb + t)]);
                chk($sformatf("%s f c%0d", tag, c), f_out, mem[wrap(fb + t)]);
            end
            // PE accumulator model driven by the DUT strobes.
            if (acc_clr) acc = 0;
            if (acc_en)  acc += int'(w_out) * int'(f_out);
            if (!hold && intr_c > 0 && c == intr_c) begin
                start  = 1'b1;
                w_base = AW'(ib_w);
                f_base = AW'(ib_f);
            end else if (!hold && intr_c > 0 && c == intr_c + 1) begin
                start = 1'b0;
            end
            tick();
        end
        check_idle({tag, " end"});
        chk({tag, " sum"}, acc, exp_sum);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        w_base   = '0;
        f_base   = '0;
        num_taps = '0;
        fill_random();

        // Reset state
        tick();
        tick();
        check_idle("reset");
        chk("reset w_out", w_out, 0);
        chk("reset f_out", f_out, 0);
        rst = 1'b1;
        tick();
        check_idle("post-reset");

        // Basic 3-tap run
        mem[0]  = 8'd2; mem[1]  = 8'd3; mem[2]  = 8'd4;
        mem[16] = 8'd5; mem[17] = 8'd6; mem[18] = 8'd7;
        run("basic", 0, 16, 3, 1'b0, 0, 0, 0);
        chk("basic pe56", acc, 56);

        // Zero taps
        run("zero", 7, 9, 0, 1'b0, 0, 0, 0);

        // Wrap-around of the weight window
        fill_random();
        run("wrap", 'h3E, 'h20, 4, 1'b0, 0, 0, 0);

        // Start with new bases while busy: ignored
        run("busystart", 8, 40, 5, 1'b0, 6, 50, 60);

        // Back-to-back with start held high
        run("b2b1", 1, 2, 3, 1'b1, 0, 0, 0);
        run("b2b2", 33, 44, 2, 1'b0, 0, 0, 0);

        // Reset in RD_F of tap 2 (cycle 11)
        start    = 1'b1;
        w_base   = AW'(5);
        f_base   = AW'(20);
        num_taps = CW'(4);
        tick();
        start = 1'b0;
        for (int c = 1; c < 11; c++) tick();
        chk("midrst addr before", ram_addr, wrap(20 + 2));
        rst = 1'b0;
        #1;
        check_idle("midrst");
        chk("midrst w_out", w_out, 0);
        chk("midrst f_out", f_out, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("midrst nodone %0d", k), done, 0);
        end
        rst = 1'b1;
        tick();
        check_idle("midrst idle");
        run("afterrst", 10, 30, 3, 1'b0, 0, 0, 0);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run($sformatf("rnd%0d", r), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 63)), int'($urandom_range(1, 12)),
                1'b0, 0, 0, 0);
        end

        // Maximum tap count
        fill_random();
        run("max", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
            (1 << CW) - 1, 1'b0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_mac_sched
